// File: rtl/ha_bist_pkg.sv
// Shared types and the golden half-adder model for the half_adder self-test engine.
package ha_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam logic [1:0] VEC_LAST = 2'b11;

  // Golden response packed as {co, sum}.
  function automatic logic [1:0] ha_expect(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/ha_bist_checker.sv
// Exhaustive 00..11 sweep generator and response checker for a half_adder cell.
// Optional build macro HA_BIST_STOP_ON_FAIL_EN: end the run at the first mismatch.
module ha_bist_checker
  import ha_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             sum_in,
  input  logic             co_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PC_W = $clog2(PASSES + 1);
  localparam logic [SC_W-1:0] SETTLE_LAST =
    (SETTLE_CYCLES > 0) ? SC_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [PC_W-1:0] PASS_LAST = PC_W'(PASSES - 1);

  state_t            state_q, state_d;
  logic [1:0]        vec_q;
  logic [PC_W-1:0]   pass_cnt_q;
  logic [SC_W-1:0]   settle_cnt_q;
  logic              first_fail_q;
  logic              mismatch;
  logic              sweep_end;
  logic              settle_end;
  logic              stop_now;

  assign mismatch   = ({co_in, sum_in} != ha_expect(a_out, b_out));
  assign sweep_end  = (vec_q == VEC_LAST) && (pass_cnt_q == PASS_LAST);
  assign settle_end = (settle_cnt_q == SETTLE_LAST);

`ifdef HA_BIST_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  assign busy = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = APPLY;
      APPLY:   state_d = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      SETTLE:  if (settle_end) state_d = CHECK;
      CHECK:   state_d = (stop_now || sweep_end) ? DONE : APPLY;
      DONE:    if (start) state_d = APPLY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out        <= 1'b0;
      b_out        <= 1'b0;
      vec_q        <= '0;
      pass_cnt_q   <= '0;
      settle_cnt_q <= '0;
      first_fail_q <= 1'b0;
      err_count    <= '0;
      fail_vec     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            vec_q        <= '0;
            pass_cnt_q   <= '0;
            settle_cnt_q <= '0;
            first_fail_q <= 1'b0;
            err_count    <= '0;
            fail_vec     <= '0;
          end
        end
        APPLY: begin
          {a_out, b_out} <= vec_q;
          settle_cnt_q   <= '0;
        end
        SETTLE: settle_cnt_q <= settle_cnt_q + 1'b1;
        CHECK: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (!first_fail_q) begin
              fail_vec     <= {a_out, b_out};
              first_fail_q <= 1'b1;
            end
          end
          vec_q <= vec_q + 1'b1;
          if (vec_q == VEC_LAST) pass_cnt_q <= pass_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result flags are registered from the DONE state, so they rise one edge
  // after the final CHECK and stay put until the next run begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      done <= (state_q == DONE);
      pass <= (state_q == DONE) && (err_count == '0);
    end
  end

endmodule

// File: doc/ha_bist_checker.md
Name: ha_bist_checker

Overview:
Synthesizable self-test engine for the half_adder cell. It drives the exhaustive 2-bit input sweep (00, 01, 10, 11) into a DUT, samples the DUT's sum/co after a settle window and compares them against a golden model. It counts mismatches and reports pass/fail. It is the response-checking end of the half_adder stimulus interface and sits beside the DUT in silicon or a bench.

Parameters:
SETTLE_CYCLES, 1, wait cycles between applying a vector and sampling DUT outputs (0 allowed)
PASSES, 1, number of full 4-vector sweeps per run (>=1)
ERR_W, 8, width of mismatch counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request run; sampled only in IDLE or DONE
a_out  output  1  DUT input a (registered)
b_out  output  1  DUT input b (registered)
sum_in  input  1  DUT sum
co_in  input  1  DUT carry out
busy  output  1  high from APPLY through last CHECK
done  output  1  level, high while in DONE
pass  output  1  valid when done: 1 iff err_count==0
err_count  output  ERR_W  mismatches, saturating at all-ones
fail_vec  output  2  {a,b} of first mismatching vector; 0 if none

Behaviour:
- Reset (async, any state): state=IDLE; a_out=b_out=0; busy=done=pass=0; err_count=0; fail_vec=0; vector and pass counters=0.
- FSM: IDLE -> APPLY -> SETTLE -> CHECK -> (APPLY | DONE); DONE -> APPLY on start.
- IDLE: start=1 clears err_count, fail_vec, counters and a first-fail flag; next state APPLY.
- APPLY (1 cycle): {a_out,b_out} <= vec; busy=1.
- SETTLE: lasts exactly SETTLE_CYCLES cycles. With SETTLE_CYCLES=0 it is skipped and APPLY goes directly to CHECK.
- CHECK (1 cycle): expected sum=a_out^b_out, co=a_out&b_out.
  - Mismatch on either bit: err_count++ (saturating). If this is the first mismatch, fail_vec={a_out,b_out}.
  - vec++ (2-bit wrap). On wrap from 11 to 00, pass_cnt++.
  - If pass_cnt reaches PASSES: go to DONE, else APPLY.
- Per-vector cost: 2+SETTLE_CYCLES cycles. Run length: 4*PASSES*(2+SETTLE_CYCLES) cycles; done rises on the next edge.
  - Defaults: start sampled at edge 0, done=1 after edge 13.
- DONE: done=1, busy=0, pass=(err_count==0). a_out/b_out hold the last vector (11). Results hold until start restarts a run.
- start while busy: ignored.
- err_count saturation: stays at 2^ERR_W-1; pass remains 0.
- Reset mid-run: immediate abort to reset values; no partial results retained.

Optional Feature:
HA_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK moves directly to DONE. err_count=1, fail_vec=failing vector, pass=0, no further vectors applied.
- Undefined: the full sweep always completes, counting all mismatches.

Decomposition:
- Package ha_bist_pkg holds:
  - state enum (IDLE, APPLY, SETTLE, CHECK, DONE)
  - constant VEC_LAST=2'b11
  - function ha_expect(a,b) returning {co,sum}
- Golden comparison uses the package function. No sub-module; FSM, counters and compare fit in one module.

Test Plan:
1. Good DUT (half_adder), defaults, start pulse at cycle 0 -> a_out/b_out step through 00,01,10,11; done at cycle 13; pass=1; err_count=0; fail_vec=00.
2. Faulty DUT with sum=a|b, PASSES=2 -> err_count=2, fail_vec=2'b11, pass=0.
3. co stuck-at-1, SETTLE_CYCLES=0 -> err_count=3, fail_vec=2'b00, done after 8 cycles.
4. Assert rst during SETTLE of vector 10 -> all outputs 0 immediately. A new start then runs the full sweep from 00.
5. ERR_W=2, PASSES=4, sum stuck-at-0 (2 errors/pass) -> err_count saturates at 3; pass=0.
6. With HA_BIST_STOP_ON_FAIL_EN and sum=a|b -> done right after CHECK of 11; err_count=1; fail_vec=11. start pulse during busy has no effect; start in DONE reruns the test.
